// File: rtl/tlul_byte_host_pkg.sv
// Frame/response byte constants and FSM state encoding for tlul_byte_host.
package tlul_byte_host_pkg;

  localparam logic [7:0] CmdWrite = 8'h57;
  localparam logic [7:0] CmdRead  = 8'h52;
  localparam logic [7:0] RspAck   = 8'h06;
  localparam logic [7:0] RspNak   = 8'h15;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StReq,
    StRsp,
    StTx
  } state_e;

endpackage

// File: rtl/tlul_pkg.sv
// TL-UL channel types: A/D structs, A opcodes and the default A-channel user field.
package tlul_pkg;

  localparam logic [2:0] PutFullData = 3'h0;
  localparam logic [2:0] Get         = 3'h4;
  localparam logic [3:0] MuBi4False  = 4'h9;

  typedef struct packed {
    logic [4:0] rsvd;
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  localparam tl_a_user_t TL_A_USER_DEFAULT = '{
    rsvd:       5'h0,
    instr_type: MuBi4False,
    cmd_intg:   7'h0,
    data_intg:  7'h0
  };

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    tl_a_user_t  a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    tl_d_user_t  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_cmd_intg_gen.sv
// A-channel integrity generator: passes the request through and fills a_user cmd/data check bits.
module tlul_cmd_intg_gen
  import tlul_pkg::*;
(
  input  tl_h2d_t tl_i,
  output tl_h2d_t tl_o
);

  // Folds a 63-bit vector into 7 check bits.
  function automatic logic [6:0] fold7(input logic [62:0] v);
    logic [6:0] r;
    r = '0;
    for (int i = 0; i < 63; i += 7) r = r ^ v[i +: 7];
    return r;
  endfunction

  always_comb begin
    tl_o = tl_i;
    tl_o.a_user.cmd_intg  = fold7(63'({tl_i.a_user.instr_type, tl_i.a_address,
                                       tl_i.a_opcode, tl_i.a_mask}));
    tl_o.a_user.data_intg = fold7(63'(tl_i.a_data));
  end

endmodule

// File: rtl/tlul_byte_host.sv
// Byte-link TL-UL host: parses 'W'/'R' frames, issues one TL-UL access, returns ACK/NAK/data.
// Define TLUL_BYTE_HOST_TIMEOUT_EN to abandon partial frames after TimeoutCycles idle cycles.
module tlul_byte_host
  import tlul_byte_host_pkg::*;
#(
  parameter int unsigned SourceId      = 0,
  parameter int unsigned TimeoutCycles = 125_000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [7:0]        rx_byte_i,
  input  logic              rx_valid_i,
  output logic [7:0]        tx_byte_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output tlul_pkg::tl_h2d_t tl_o,
  input  tlul_pkg::tl_d2h_t tl_i,
  output logic              busy_o,
  output logic              overrun_o
);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d, tx_cnt_q, tx_cnt_d;
  logic              is_write_q, is_write_d, overrun_q, overrun_d;
  logic [31:0]       addr_q, addr_d, data_q, data_d, rsp_q, rsp_d;
  logic              timeout;
  tlul_pkg::tl_h2d_t tl_pre;
  logic              unused_d;

`ifdef TLUL_BYTE_HOST_TIMEOUT_EN
  logic [31:0] to_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_q <= '0;
    end else if ((state_q == StAddr || state_q == StData) && !rx_valid_i) begin
      to_q <= to_q + 32'd1;
    end else begin
      to_q <= '0;
    end
  end

  assign timeout = (to_q == 32'(TimeoutCycles - 1));
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = TimeoutCycles;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_cnt_d   = tx_cnt_q;
    is_write_d = is_write_q;
    overrun_d  = overrun_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rsp_d      = rsp_q;
    if (rx_valid_i && (state_q == StReq || state_q == StRsp || state_q == StTx)) begin
      overrun_d = 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        if (rx_valid_i) begin
          cnt_d = 2'd0;
          if (rx_byte_i == CmdWrite || rx_byte_i == CmdRead) begin
            is_write_d = (rx_byte_i == CmdWrite);
            state_d    = StAddr;
          end else begin
            rsp_d    = {24'h0, RspNak};
            tx_cnt_d = 2'd0;
            state_d  = StTx;
          end
        end
      end
      StAddr: begin
        if (rx_valid_i) begin
          addr_d[8*cnt_q +: 8] = rx_byte_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (is_write_q) begin
              state_d = StData;
            end else if (addr_q[1:0] != 2'b00) begin
              rsp_d    = {24'h0, RspNak};
              tx_cnt_d = 2'd0;
              state_d  = StTx;
            end else begin
              state_d = StReq;
            end
          end
        end
      end
      StData: begin
        if (rx_valid_i) begin
          data_d[8*cnt_q +: 8] = rx_byte_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (addr_q[1:0] != 2'b00) begin
              rsp_d    = {24'h0, RspNak};
              tx_cnt_d = 2'd0;
              state_d  = StTx;
            end else begin
              state_d = StReq;
            end
          end
        end
      end
      StReq: begin
        if (tl_i.a_ready) state_d = StRsp;
      end
      StRsp: begin
        if (tl_i.d_valid) begin
          state_d = StTx;
          if (tl_i.d_error) begin
            rsp_d    = {24'h0, RspNak};
            tx_cnt_d = 2'd0;
          end else if (is_write_q) begin
            rsp_d    = {24'h0, RspAck};
            tx_cnt_d = 2'd0;
          end else begin
            rsp_d    = tl_i.d_data;
            tx_cnt_d = 2'd3;
          end
        end
      end
      StTx: begin
        if (tx_ready_i) begin
          if (tx_cnt_q == 2'd0) begin
            state_d = StIdle;
          end else begin
            rsp_d    = rsp_q >> 8;
            tx_cnt_d = tx_cnt_q - 2'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Silent abandon of a stalled partial frame; a byte arriving this cycle still wins.
    if (timeout && !rx_valid_i) state_d = StIdle;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      tx_cnt_q   <= '0;
      is_write_q <= 1'b0;
      overrun_q  <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rsp_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      is_write_q <= is_write_d;
      overrun_q  <= overrun_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rsp_q      <= rsp_d;
    end
  end

  // Payload is zero outside REQ so idle/reset A-channel fields read as defaults.
  always_comb begin
    tl_pre         = '0;
    tl_pre.a_user  = tlul_pkg::TL_A_USER_DEFAULT;
    tl_pre.d_ready = 1'b1;
    if (state_q == StReq) begin
      tl_pre.a_valid   = 1'b1;
      tl_pre.a_opcode  = is_write_q ? tlul_pkg::PutFullData : tlul_pkg::Get;
      tl_pre.a_size    = 2'd2;
      tl_pre.a_source  = 8'(SourceId);
      tl_pre.a_address = addr_q;
      tl_pre.a_mask    = 4'hF;
      tl_pre.a_data    = is_write_q ? data_q : 32'h0;
    end
  end

  tlul_cmd_intg_gen u_cmd_intg_gen (
    .tl_i (tl_pre),
    .tl_o (tl_o)
  );

  assign tx_valid_o = (state_q == StTx);
  assign tx_byte_o  = (state_q == StTx) ? rsp_q[7:0] : 8'h00;
  assign busy_o     = (state_q != StIdle);
  assign overrun_o  = overrun_q;

  assign unused_d = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_source, tl_i.d_sink,
                      tl_i.d_user};

endmodule

// File: tb/tb_tlul_byte_host.sv
// Directed bench for tlul_byte_host with TX-byte and A-request scoreboards.
// Timeout scenario runs only when TLUL_BYTE_HOST_TIMEOUT_EN is defined.
module tb_tlul_byte_host;
  import tlul_pkg::*;

  localparam int unsigned SrcId = 5;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  tl_h2d_t     tl_o;
  tl_d2h_t     tl_i;
  logic        busy;
  logic        overrun;

  tlul_byte_host #(
    .SourceId      (SrcId),
    .TimeoutCycles (100)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .rx_byte_i  (rx_byte),
    .rx_valid_i (rx_valid),
    .tx_byte_o  (tx_byte),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready),
    .tl_o       (tl_o),
    .tl_i       (tl_i),
    .busy_o     (busy),
    .overrun_o  (overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
  } a_exp_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  a_exp_t     exp_a[$];
  logic [7:0] exp_tx[$];
  a_exp_t     a_cur;
  int         a_hs = 0;
  int         a_cycles = 0;
  int         tx_hs = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboards: TX bytes and A-channel requests, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_ni && tx_valid && tx_ready) begin
      tx_hs++;
      check("tx_expected", 32'(exp_tx.size() != 0), 32'd1);
      if (exp_tx.size() != 0) check("tx_byte", 32'(tx_byte), 32'(exp_tx.pop_front()));
    end
    if (rst_ni && tl_o.a_valid) begin
      a_cycles++;
      if (tl_i.a_ready) begin
        a_hs++;
        check("a_expected", 32'(exp_a.size() != 0), 32'd1);
        if (exp_a.size() != 0) begin
          a_cur = exp_a.pop_front();
          check("a_opcode", 32'(tl_o.a_opcode), 32'(a_cur.op));
          check("a_address", tl_o.a_address, a_cur.addr);
          if (a_cur.op == PutFullData) check("a_data", tl_o.a_data, a_cur.data);
          check("a_mask", 32'(tl_o.a_mask), 32'hF);
          check("a_size", 32'(tl_o.a_size), 32'd2);
          check("a_source", 32'(tl_o.a_source), 32'(SrcId));
          check("a_instr_type", 32'(tl_o.a_user.instr_type), 32'h9);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr,
                            input logic [31:0] data);
    send(cmd);
    for (int i = 0; i < 4; i++) send(addr[8*i +: 8]);
    if (cmd == 8'h57) for (int i = 0; i < 4; i++) send(data[8*i +: 8]);
  endtask

  // Device side: optional A backpressure, optional RX poke during RSP, then one D beat.
  task automatic respond(input int delay, input logic [31:0] exp_addr, input logic [31:0] exp_data,
                         input logic [31:0] rdata, input logic err, input bit poke_rx);
    int budget = 0;
    while (!tl_o.a_valid && budget < 20) begin
      tick();
      budget++;
    end
    check("a_valid_seen", 32'(tl_o.a_valid), 32'd1);
    for (int i = 0; i < delay; i++) begin
      check("bp_valid_held", 32'(tl_o.a_valid), 32'd1);
      check("bp_addr_stable", tl_o.a_address, exp_addr);
      check("bp_data_stable", tl_o.a_data, exp_data);
      tick();
    end
    tl_i.a_ready = 1'b1;
    tick();
    tl_i.a_ready = 1'b0;
    if (poke_rx) begin
      rx_byte  = 8'hAA;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      check("overrun_set", 32'(overrun), 32'd1);
      check("busy_in_rsp", 32'(busy), 32'd1);
    end
    tl_i.d_valid  = 1'b1;
    tl_i.d_opcode = 3'h1;
    tl_i.d_data   = rdata;
    tl_i.d_error  = err;
    tick();
    tl_i.d_valid = 1'b0;
    tl_i.d_error = 1'b0;
  endtask

  task automatic drain(input string tag);
    int budget = 0;
    while ((exp_tx.size() != 0 || busy) && budget < 50) begin
      tick();
      budget++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_tx_left"}, 32'(exp_tx.size()), 32'd0);
  endtask

  initial begin
    int a0;
    int t0;
    rst_ni   = 1'b0;
    rx_byte  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    tl_i     = '0;
    #2;
    check("rst_a_valid", 32'(tl_o.a_valid), 32'd0);
    check("rst_d_ready", 32'(tl_o.d_ready), 32'd1);
    check("rst_a_address", tl_o.a_address, 32'h0);
    check("rst_a_data", tl_o.a_data, 32'h0);
    check("rst_a_opcode", 32'(tl_o.a_opcode), 32'h0);
    check("rst_a_mask", 32'(tl_o.a_mask), 32'h0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    tick();

    // Write
    exp_a.push_back('{op: PutFullData, addr: 32'h0001_0000, data: 32'hDEAD_BEEF});
    exp_tx.push_back(8'h06);
    send_frame(8'h57, 32'h0001_0000, 32'hDEAD_BEEF);
    check("wr_a_valid_latency", 32'(tl_o.a_valid), 32'd1);
    check("wr_busy", 32'(busy), 32'd1);
    respond(0, 32'h0001_0000, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
    check("wr_tx_latency", 32'(tx_valid), 32'd1);
    drain("wr");

    // Read with TX backpressure on byte 2
    exp_a.push_back('{op: Get, addr: 32'h0001_0000, data: 32'h0});
    exp_tx.push_back(8'h78);
    exp_tx.push_back(8'h56);
    exp_tx.push_back(8'h34);
    exp_tx.push_back(8'h12);
    send_frame(8'h52, 32'h0001_0000, 32'h0);
    check("rd_a_valid_latency", 32'(tl_o.a_valid), 32'd1);
    respond(0, 32'h0001_0000, 32'h0, 32'h1234_5678, 1'b0, 1'b0);
    check("rd_tx_first", 32'(tx_byte), 32'h78);
    tick();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("rd_hold_valid", 32'(tx_valid), 32'd1);
      check("rd_hold_byte", 32'(tx_byte), 32'h56);
      tick();
    end
    tx_ready = 1'b1;
    drain("rd");

    // D error
    exp_a.push_back('{op: Get, addr: 32'h0000_2000, data: 32'h0});
    exp_tx.push_back(8'h15);
    send_frame(8'h52, 32'h0000_2000, 32'h0);
    respond(0, 32'h0000_2000, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    drain("derr");

    // Misaligned read and write: NAK, no A request
    a0 = a_cycles;
    exp_tx.push_back(8'h15);
    send_frame(8'h52, 32'h0000_0002, 32'h0);
    check("mis_rd_tx_valid", 32'(tx_valid), 32'd1);
    check("mis_rd_tx_byte", 32'(tx_byte), 32'h15);
    drain("mis_rd");
    exp_tx.push_back(8'h15);
    send_frame(8'h57, 32'h0000_0101, 32'h1111_2222);
    check("mis_wr_tx_byte", 32'(tx_byte), 32'h15);
    drain("mis_wr");
    check("mis_no_a_valid", 32'(a_cycles - a0), 32'd0);

    // Unknown command
    exp_tx.push_back(8'h15);
    send(8'h41);
    check("unk_tx_valid", 32'(tx_valid), 32'd1);
    check("unk_tx_byte", 32'(tx_byte), 32'h15);
    drain("unk");

    // A-channel backpressure
    a0 = a_hs;
    exp_a.push_back('{op: PutFullData, addr: 32'h0000_1004, data: 32'h0BAD_F00D});
    exp_tx.push_back(8'h06);
    send_frame(8'h57, 32'h0000_1004, 32'h0BAD_F00D);
    respond(10, 32'h0000_1004, 32'h0BAD_F00D, 32'h0, 1'b0, 1'b0);
    drain("bp");
    check("bp_one_handshake", 32'(a_hs - a0), 32'd1);
    check("overrun_clear", 32'(overrun), 32'd0);

    // Overrun during RSP
    exp_a.push_back('{op: Get, addr: 32'h0000_0020, data: 32'h0});
    exp_tx.push_back(8'h0D);
    exp_tx.push_back(8'hF0);
    exp_tx.push_back(8'hFE);
    exp_tx.push_back(8'hCA);
    send_frame(8'h52, 32'h0000_0020, 32'h0);
    respond(0, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1);
    drain("ovr");
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Reset during REQ, then a stale D beat
    send_frame(8'h52, 32'h0000_0040, 32'h0);
    check("rreq_a_valid", 32'(tl_o.a_valid), 32'd1);
    rst_ni = 1'b0;
    #1;
    check("rreq_a_valid_rst", 32'(tl_o.a_valid), 32'd0);
    check("rreq_d_ready_rst", 32'(tl_o.d_ready), 32'd1);
    check("rreq_a_address_rst", tl_o.a_address, 32'h0);
    check("rreq_tx_valid_rst", 32'(tx_valid), 32'd0);
    check("rreq_tx_byte_rst", 32'(tx_byte), 32'h0);
    check("rreq_busy_rst", 32'(busy), 32'd0);
    check("rreq_overrun_rst", 32'(overrun), 32'd0);
    tick();
    rst_ni        = 1'b1;
    tl_i.d_valid  = 1'b1;
    tl_i.d_data   = 32'h9999_9999;
    tick();
    tl_i.d_valid = 1'b0;
    tick();
    check("stale_d_busy", 32'(busy), 32'd0);
    check("stale_d_tx_valid", 32'(tx_valid), 32'd0);

`ifdef TLUL_BYTE_HOST_TIMEOUT_EN
    a0 = a_hs;
    t0 = tx_hs;
    send(8'h57);
    send(8'h00);
    send(8'h00);
    check("to_busy", 32'(busy), 32'd1);
    repeat (101) tick();
    check("to_idle", 32'(busy), 32'd0);
    check("to_no_tx", 32'(tx_hs - t0), 32'd0);
    check("to_no_a", 32'(a_hs - a0), 32'd0);
    exp_a.push_back('{op: PutFullData, addr: 32'h0000_0100, data: 32'h55AA_55AA});
    exp_tx.push_back(8'h06);
    send_frame(8'h57, 32'h0000_0100, 32'h55AA_55AA);
    respond(0, 32'h0000_0100, 32'h55AA_55AA, 32'h0, 1'b0, 1'b0);
    drain("to_wr");
`else
    t0 = tx_hs;
    a0 = a_hs;
`endif

    repeat (3) tick();
    check("end_a_left", 32'(exp_a.size()), 32'd0);
    check("end_tx_left", 32'(exp_tx.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
